sponge_arbiter: RTL and testbench

SPONGE_ARBITER -- requirements
Module: sponge_arbiter

---
 rtl/sponge_pkg.sv | 31 +++
 rtl/rr_arb2.sv | 32 +++
 rtl/sponge_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_sponge_arbiter.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sponge_pkg.sv
// ---------------------------------------------------------------------------
// sponge_pkg
// Shared widths, limits and the FSM state type for the sponge job arbiter.
//   SPONGE_IN_W  : seed/coins width fed to the sponge core
//   SPONGE_OUT_W : widest squeeze result the sponge core can return
//   LEN_W        : width of the requested output length (in bits)
//   MAX_LEN      : largest legal output length (bits)
//   DOM_W        : domain-separation field width
// ---------------------------------------------------------------------------
package sponge_pkg;

    localparam int SPONGE_IN_W  = 256;
    localparam int SPONGE_OUT_W = 5376;
    localparam int LEN_W        = 14;
    localparam int MAX_LEN      = 5376;
    localparam int DOM_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    // A length is usable only if it is non-zero, fits the output buffer and
    // is a whole number of bytes.
    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len != '0) && (len <= LEN_W'(MAX_LEN)) && (len[2:0] == 3'b000);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin choice. The pointer names the requester that wins a
// tie; the caller moves it away from whoever was last served.
//   req_i [1:0] : request lines (bit n = requester n)
//   ptr_i       : favoured requester index
//   gnt_o [1:0] : one-hot choice, all zero when nothing is requested
// ---------------------------------------------------------------------------
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       ptr_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (ptr_i == 1'b0) begin
            if (req_i[0]) begin
                gnt_o = 2'b01;
            end else if (req_i[1]) begin
                gnt_o = 2'b10;
            end
        end else begin
            if (req_i[1]) begin
                gnt_o = 2'b10;
            end else if (req_i[0]) begin
                gnt_o = 2'b01;
            end
        end
    end

endmodule

// File: rtl/sponge_arbiter.sv
// ---------------------------------------------------------------------------
// sponge_arbiter
// Shares one sponge core between two requesters. A job is accepted from the
// round-robin winner, the core is cleared for one cycle, then enabled until it
// reports done or the job times out; the result is held until the response
// handshake completes.
//   clk, rst               : clock, async active-low reset
//   req0/req1 (+_in, _domain, _len) : job requests and their parameters
//   gnt                    : one-cycle one-hot acceptance pulse
//   rsp_valid/rsp_ready    : response handshake
//   rsp_id/rsp_err/rsp_data: served requester, failure flag, squeezed output
//   sp_rst/sp_enable       : sponge clear (active high) and run enable
//   sp_in/sp_domain/sp_output_len : latched job parameters to the sponge
//   sp_done/sp_output_string      : sponge completion and result
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for a request, arbitration active
// ST_CLR  | one-cycle sponge clear before running
// ST_RUN  | sponge enabled, counting cycles towards the timeout
// ST_RESP | response presented, waiting for rsp_ready
// ---------------------------------------------------------------------------
module sponge_arbiter
    import sponge_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0,
    input  logic                    req1,
    input  logic [SPONGE_IN_W-1:0]  req0_in,
    input  logic [SPONGE_IN_W-1:0]  req1_in,
    input  logic [DOM_W-1:0]        req0_domain,
    input  logic [DOM_W-1:0]        req1_domain,
    input  logic [LEN_W-1:0]        req0_len,
    input  logic [LEN_W-1:0]        req1_len,
    output logic [1:0]              gnt,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic                    rsp_err,
    output logic [SPONGE_OUT_W-1:0] rsp_data,
    output logic                    sp_rst,
    output logic                    sp_enable,
    output logic [SPONGE_IN_W-1:0]  sp_in,
    output logic [DOM_W-1:0]        sp_domain,
    output logic [LEN_W-1:0]        sp_output_len,
    input  logic                    sp_done,
    input  logic [SPONGE_OUT_W-1:0] sp_output_string
);

    // Counter must be able to hold TIMEOUT_CYCLES itself.
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic                    ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              gnt_q, gnt_d;
    logic                    id_q, id_d;
    logic                    err_q, err_d;
    logic [SPONGE_OUT_W-1:0] data_q, data_d;
    logic [SPONGE_IN_W-1:0]  in_q, in_d;
    logic [DOM_W-1:0]        dom_q, dom_d;
    logic [LEN_W-1:0]        len_q, len_d;

    logic [1:0]              arb_gnt;
    logic                    sel_id;
    logic [SPONGE_IN_W-1:0]  sel_in;
    logic [DOM_W-1:0]        sel_dom;
    logic [LEN_W-1:0]        sel_len;

    rr_arb2 u_rr_arb2 (
        .req_i (({req1, req0})),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt)
    );

    assign sel_id  = arb_gnt[1];
    assign sel_in  = sel_id ? req1_in     : req0_in;
    assign sel_dom = sel_id ? req1_domain : req0_domain;
    assign sel_len = sel_id ? req1_len    : req0_len;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = 2'b00;
        id_d    = id_q;
        err_d   = err_q;
        data_d  = data_q;
        in_d    = in_q;
        dom_d   = dom_q;
        len_d   = len_q;

        unique case (state_q)
            ST_IDLE: begin
                if (arb_gnt != 2'b00) begin
                    gnt_d = arb_gnt;
                    id_d  = sel_id;
                    in_d  = sel_in;
                    dom_d = sel_dom;
                    len_d = sel_len;
                    cnt_d = '0;
                    if (len_legal(sel_len)) begin
                        state_d = ST_CLR;
                    end else begin
                        // Unusable length never touches the sponge.
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_CLR: begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                // Completion takes priority over a coincident timeout.
                if (sp_done) begin
                    data_d  = sp_output_string;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    // Last served requester loses the next tie.
                    ptr_d   = ~id_q;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            gnt_q   <= 2'b00;
            id_q    <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            in_q    <= '0;
            dom_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            err_q   <= err_d;
            data_q  <= data_d;
            in_q    <= in_d;
            dom_q   <= dom_d;
            len_q   <= len_d;
        end
    end

    assign gnt           = gnt_q;
    assign rsp_valid     = (state_q == ST_RESP);
    assign rsp_id        = id_q;
    assign rsp_err       = err_q;
    assign rsp_data      = data_q;
    assign sp_rst        = (state_q == ST_CLR);
    assign sp_enable     = (state_q == ST_RUN);
    assign sp_in         = in_q;
    assign sp_domain     = dom_q;
    assign sp_output_len = len_q;

endmodule

// File: tb/tb_sponge_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sponge_arbiter
// Randomised and directed jobs against a transaction-level reference:
// requesters are served round-robin whenever the arbiter is free, each job
// answers with the sponge result, or an error for bad lengths and timeouts.
// A behavioural sponge drives sp_done / sp_output_string.
// ---------------------------------------------------------------------------
module tb_sponge_arbiter;
    import sponge_pkg::*;

    localparam int TO = 255;

    typedef struct {
        logic [SPONGE_IN_W-1:0] din;
        logic [DOM_W-1:0]       dom;
        logic [LEN_W-1:0]       len;
    } job_t;

    typedef struct {
        logic                    id;
        logic                    err;
        logic                    legal;
        logic                    stuck;
        logic [SPONGE_OUT_W-1:0] data;
    } exp_t;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    req0 = 1'b0, req1 = 1'b0;
    logic [SPONGE_IN_W-1:0]  req0_in = '0, req1_in = '0;
    logic [DOM_W-1:0]        req0_domain = '0, req1_domain = '0;
    logic [LEN_W-1:0]        req0_len = '0, req1_len = '0;
    logic [1:0]              gnt;
    logic                    rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_err;
    logic [SPONGE_OUT_W-1:0] rsp_data;
    logic                    sp_rst, sp_enable, sp_done = 1'b0;
    logic [SPONGE_IN_W-1:0]  sp_in;
    logic [DOM_W-1:0]        sp_domain;
    logic [LEN_W-1:0]        sp_output_len;
    logic [SPONGE_OUT_W-1:0] sp_output_string = '0;

    int checks = 0;
    int errors = 0;

    bit   in_rst = 1'b1;
    bit   stuck = 1'b0;
    int   ready_mode = 0;
    int   stall_n = 0;
    int   env_cnt = 0;
    int   env_lat = 1;

    job_t jq0[$], jq1[$];
    job_t cur0, cur1;

    exp_t sb[$];
    exp_t mon_e;
    logic [1:0] exp_gnt_q = 2'b00;
    logic [1:0] mon_rq, mon_w;
    bit   idle_m = 1'b1;
    bit   ptr_m = 1'b0;
    int   en_cnt = 0, rst_cnt = 0;
    int   resp_cnt = 0;
    int   ids_seen[$];

    always #5 clk = ~clk;

    sponge_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .req0_in(req0_in), .req1_in(req1_in),
        .req0_domain(req0_domain), .req1_domain(req1_domain),
        .req0_len(req0_len), .req1_len(req1_len),
        .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_err(rsp_err), .rsp_data(rsp_data),
        .sp_rst(sp_rst), .sp_enable(sp_enable), .sp_in(sp_in),
        .sp_domain(sp_domain), .sp_output_len(sp_output_len),
        .sp_done(sp_done), .sp_output_string(sp_output_string)
    );

    task automatic check_val(input string tag, input logic [SPONGE_OUT_W-1:0] got,
                             input logic [SPONGE_OUT_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got(low128)=%0h exp(low128)=%0h", tag, got[127:0], exp[127:0]);
        end
    endtask

    function automatic bit legal_len(input int len);
        return (len >= 1) && (len <= MAX_LEN) && (len % 8 == 0);
    endfunction

    // Stand-in for the real sponge: a deterministic mix of the job fields,
    // truncated to the requested number of bits.
    function automatic logic [SPONGE_OUT_W-1:0] sponge_fn(input logic [SPONGE_IN_W-1:0] din,
                                                          input logic [DOM_W-1:0] dom,
                                                          input logic [LEN_W-1:0] len);
        logic [SPONGE_OUT_W-1:0] o;
        logic [SPONGE_OUT_W-1:0] m;
        logic [31:0] w;
        for (int i = 0; i < SPONGE_OUT_W / 32; i++) begin
            w = din[(i % 8) * 32 +: 32] ^ (32'(i) * 32'h9e3779b9) ^ {14'd0, len, dom};
            o[i * 32 +: 32] = w;
        end
        m = '1;
        m = m >> (SPONGE_OUT_W - int'(len));
        return o & m;
    endfunction

    function automatic logic [SPONGE_IN_W-1:0] rand256();
        logic [SPONGE_IN_W-1:0] r;
        for (int i = 0; i < 8; i++) r[i * 32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SPONGE_OUT_W-1:0] junk();
        logic [SPONGE_OUT_W-1:0] r;
        for (int i = 0; i < SPONGE_OUT_W / 32; i++) r[i * 32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic wait_gnt(input int id);
        bit got = 1'b0;
        for (int n = 0; n < 4000 && !got; n++) begin
            @(negedge clk);
            got = gnt[id];
        end
        check_val(id == 0 ? "gnt_wait0" : "gnt_wait1", got, 1);
        @(posedge clk);
        #2;
    endtask

    initial begin : drv0
        job_t j;
        forever begin
            @(posedge clk);
            #2;
            if (!in_rst && jq0.size() > 0) begin
                j = jq0.pop_front();
                cur0 = j;
                req0_in = j.din; req0_domain = j.dom; req0_len = j.len;
                req0 = 1'b1;
                wait_gnt(0);
                req0 = 1'b0;
            end
        end
    end

    initial begin : drv1
        job_t j;
        forever begin
            @(posedge clk);
            #2;
            if (!in_rst && jq1.size() > 0) begin
                j = jq1.pop_front();
                cur1 = j;
                req1_in = j.din; req1_domain = j.dom; req1_len = j.len;
                req1 = 1'b1;
                wait_gnt(1);
                req1 = 1'b0;
            end
        end
    end

    initial begin : drv_ready
        forever begin
            @(posedge clk);
            #2;
            case (ready_mode)
                0: rsp_ready = 1'b1;
                1: rsp_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (rsp_valid && stall_n < 20) begin
                        rsp_ready = 1'b0;
                        stall_n++;
                    end else if (rsp_valid) begin
                        rsp_ready = 1'b1;
                    end else begin
                        rsp_ready = 1'b0;
                        stall_n = 0;
                    end
                end
            endcase
        end
    end

    // Behavioural sponge: done after env_lat enabled cycles, never when stuck.
    always @(negedge clk) begin
        if (sp_rst) begin
            env_cnt = 0;
            env_lat = $urandom_range(1, 12);
        end
        if (sp_enable) env_cnt++;
        if (sp_enable && !stuck && env_cnt == env_lat) begin
            sp_done = 1'b1;
            sp_output_string = sponge_fn(sp_in, sp_domain, sp_output_len);
        end else begin
            sp_done = 1'b0;
            sp_output_string = junk();
        end
    end

    // Reference model and scoreboard.
    always @(negedge clk) begin
        if (in_rst) begin
            sb.delete();
            exp_gnt_q = 2'b00;
            idle_m = 1'b1;
            ptr_m = 1'b0;
            en_cnt = 0;
            rst_cnt = 0;
        end else begin
            check_val("gnt", gnt, exp_gnt_q);
            if (sp_enable) en_cnt++;
            if (sp_rst) rst_cnt++;

            mon_rq = {req1, req0};
            exp_gnt_q = 2'b00;
            if (idle_m && mon_rq != 2'b00) begin
                if (mon_rq[ptr_m]) mon_w = ptr_m ? 2'b10 : 2'b01;
                else               mon_w = ptr_m ? 2'b01 : 2'b10;
                exp_gnt_q = mon_w;
                idle_m = 1'b0;
                mon_e.id = mon_w[1];
                if (mon_w[1]) begin
                    mon_e.legal = legal_len(int'(cur1.len));
                    mon_e.data = sponge_fn(cur1.din, cur1.dom, cur1.len);
                end else begin
                    mon_e.legal = legal_len(int'(cur0.len));
                    mon_e.data = sponge_fn(cur0.din, cur0.dom, cur0.len);
                end
                mon_e.stuck = stuck;
                mon_e.err = !mon_e.legal || stuck;
                if (mon_e.err) mon_e.data = '0;
                sb.push_back(mon_e);
                en_cnt = 0;
                rst_cnt = 0;
            end

            if (rsp_valid) begin
                if (sb.size() == 0) begin
                    check_val("rsp_unexpected", rsp_valid, 0);
                end else if (!idle_m) begin
                    mon_e = sb[0];
                    check_val("rsp_id", rsp_id, mon_e.id);
                    check_val("rsp_err", rsp_err, mon_e.err);
                    check_val("rsp_data", rsp_data, mon_e.data);
                    check_val("sp_enable_in_resp", sp_enable, 0);
                    if (rsp_ready) begin
                        check_val("clr_cycles", rst_cnt, mon_e.legal ? 1 : 0);
                        check_val("run_cycles", en_cnt,
                                  !mon_e.legal ? 0 : (mon_e.stuck ? TO : env_lat));
                        ptr_m = ~mon_e.id;
                        idle_m = 1'b1;
                        ids_seen.push_back(int'(mon_e.id));
                        resp_cnt++;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_resp(input int target);
        for (int n = 0; n < 20000 && resp_cnt < target; n++) @(negedge clk);
        check_val("resp_count", resp_cnt, target);
    endtask

    task automatic do_reset();
        in_rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check_val("rst_gnt", gnt, 0);
        check_val("rst_rsp_valid", rsp_valid, 0);
        check_val("rst_rsp_id", rsp_id, 0);
        check_val("rst_rsp_err", rsp_err, 0);
        check_val("rst_rsp_data", rsp_data, 0);
        check_val("rst_sp_enable", sp_enable, 0);
        check_val("rst_sp_rst", sp_rst, 0);
        check_val("rst_sp_in", sp_in, 0);
        check_val("rst_sp_domain", sp_domain, 0);
        check_val("rst_sp_len", sp_output_len, 0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        in_rst = 1'b0;
    endtask

    function automatic job_t mk_job(input logic [LEN_W-1:0] len);
        job_t j;
        j.din = rand256();
        j.dom = 4'($urandom_range(0, 15));
        j.len = len;
        return j;
    endfunction

    initial begin : main
        job_t j;
        int   base, idx, n, r;
        logic [1:0] pat;

        do_reset();

        // Fixed vector, requester 0 alone.
        ready_mode = 0;
        base = resp_cnt;
        j.din = {32'hf8f11229, 192'h0123456789abcdef_fedcba9876543210_0f1e2d3c4b5a6978, 32'hc9665598};
        j.dom = 4'b1111;
        j.len = 14'd1024;
        jq0.push_back(j);
        wait_resp(base + 1);

        // Simultaneous requests after reset, twice each: 0,1,0,1.
        do_reset();
        base = resp_cnt;
        idx = ids_seen.size();
        jq0.push_back(mk_job(14'd5376)); jq1.push_back(mk_job(14'd5376));
        jq0.push_back(mk_job(14'd5376)); jq1.push_back(mk_job(14'd5376));
        wait_resp(base + 4);
        check_val("rr_order_len", ids_seen.size() - idx, 4);
        if (ids_seen.size() - idx == 4) begin
            for (int i = 0; i < 4; i++) check_val("rr_order", ids_seen[idx + i], i % 2);
        end

        // Response held off 20 cycles with requester 1 waiting.
        ready_mode = 2;
        base = resp_cnt;
        jq0.push_back(mk_job(14'd512));
        repeat (3) @(negedge clk);
        jq1.push_back(mk_job(14'd64));
        wait_resp(base + 2);
        ready_mode = 0;

        // Illegal lengths.
        base = resp_cnt;
        jq0.push_back(mk_job(14'd0));
        jq1.push_back(mk_job(14'd5377));
        jq0.push_back(mk_job(14'd1001));
        wait_resp(base + 3);

        // Stuck sponge times out, then a normal job.
        stuck = 1'b1;
        base = resp_cnt;
        jq1.push_back(mk_job(14'd256));
        wait_resp(base + 1);
        stuck = 1'b0;
        jq0.push_back(mk_job(14'd8));
        wait_resp(base + 2);

        // Random traffic with random back-pressure.
        ready_mode = 1;
        for (int it = 0; it < 40; it++) begin
            pat = 2'($urandom_range(1, 3));
            base = resp_cnt;
            n = 0;
            for (int k = 0; k < 2; k++) begin
                if (pat[k]) begin
                    r = $urandom_range(0, 9);
                    if (r == 0) j = mk_job(14'($urandom_range(0, 16383)));
                    else        j = mk_job(14'($urandom_range(1, 672) * 8));
                    if (k == 0) jq0.push_back(j);
                    else        jq1.push_back(j);
                    n++;
                end
            end
            wait_resp(base + n);
        end
        ready_mode = 0;

        // Reset during RUN abandons the job; next job completes cleanly.
        stuck = 1'b1;
        jq0.push_back(mk_job(14'd128));
        n = 0;
        for (int k = 0; k < 200 && n < 5; k++) begin
            @(negedge clk);
            if (sp_enable) n++;
        end
        check_val("run_reached", n, 5);
        stuck = 1'b0;
        do_reset();
        base = resp_cnt;
        idx = ids_seen.size();
        jq0.push_back(mk_job(14'd2048));
        wait_resp(base + 1);
        check_val("post_reset_id", (ids_seen.size() > idx) ? ids_seen[idx] : 99, 0);

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
